// File: rtl/mc6809_irq_pkg.sv
// rtl/mc6809_irq_pkg.sv - shared register offsets and acknowledge FSM states
package mc6809_irq_pkg;

    localparam logic [1:0] IRQ_PEND   = 2'd0;
    localparam logic [1:0] IRQ_MASK   = 2'd1;
    localparam logic [1:0] IRQ_FSEL   = 2'd2;
    localparam logic [1:0] IRQ_ACTIVE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        REL  = 2'd2
    } irq_ack_state_t;

endpackage

// File: rtl/mc6809_irq_prio.sv
// rtl/mc6809_irq_prio.sv - lowest-index-wins priority encoder
module mc6809_irq_prio #(
    parameter int N = 8
) (
    input  logic [N-1:0] req_i,
    output logic         valid_o,
    output logic [2:0]   idx_o
);

    // Scan from the top down so the last hit, the lowest index, is kept.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = 3'd0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/mc6809_irq_ctrl.sv
// rtl/mc6809_irq_ctrl.sv - prioritised IRQ/FIRQ controller with vector supply for the 6809 core
module mc6809_irq_ctrl
    import mc6809_irq_pkg::*;
#(
    parameter int          NSRC        = 8,
    parameter logic [15:0] VEC_BASE    = 16'hFFC0,
    parameter logic [15:0] DEFAULT_VEC = 16'hFFF8
) (
    input  logic            CLK,
    input  logic            nRESET,
    input  logic [NSRC-1:0] REQ,
    input  logic            CS,
    input  logic [1:0]      A,
    input  logic            RnW,
    input  logic [7:0]      DIn,
    output logic [7:0]      DOut,
    input  logic            BS,
    input  logic            BA,
    output logic            nIRQ,
    output logic            nFIRQ,
    output logic [15:0]     Intvector
);

    logic [NSRC-1:0] req_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic [NSRC-1:0] fsel_q, fsel_d;
    logic            nirq_q, nfirq_q;
    logic [15:0]     vec_q, vec_d;
    irq_ack_state_t  state_q, state_d;
    logic [2:0]      act_idx_q, act_idx_d;
    logic            act_valid_q, act_valid_d;

    logic [NSRC-1:0] edge_set, wclr, ackclr;
    logic [NSRC-1:0] firq_act, irq_act;
    logic            firq_v, irq_v, sel_valid;
    logic [2:0]      firq_idx, irq_idx, sel_idx;
    logic [15:0]     sel_vec;
    logic            wr_en, vec_fetch;

    assign wr_en     = CS & ~RnW;
    assign vec_fetch = BS & ~BA;
    assign edge_set  = REQ & ~req_q;
    assign wclr      = (wr_en && A == IRQ_PEND) ? DIn[NSRC-1:0] : '0;

    assign firq_act  = pend_q & mask_q & fsel_q;
    assign irq_act   = pend_q & mask_q & ~fsel_q;

    mc6809_irq_prio #(.N(NSRC)) u_prio_firq (
        .req_i   (firq_act),
        .valid_o (firq_v),
        .idx_o   (firq_idx)
    );

    mc6809_irq_prio #(.N(NSRC)) u_prio_irq (
        .req_i   (irq_act),
        .valid_o (irq_v),
        .idx_o   (irq_idx)
    );

    // FIRQ class always outranks IRQ class, mirroring the CPU's own ordering.
    assign sel_valid = firq_v | irq_v;
    assign sel_idx   = firq_v ? firq_idx : irq_idx;
    assign sel_vec   = sel_valid ? (VEC_BASE + {12'd0, sel_idx, 1'b0}) : DEFAULT_VEC;

    // Acknowledge sequencing: freeze the selection on vector fetch, retire it when fetch ends.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        act_idx_d   = act_idx_q;
        act_valid_d = act_valid_q;
        ackclr      = '0;
        case (state_q)
            IDLE: begin
                vec_d = sel_vec;
                if (vec_fetch) begin
                    act_idx_d   = sel_idx;
                    act_valid_d = sel_valid;
                    state_d     = ACK;
                end
            end
            ACK: begin
                if (!vec_fetch) begin
                    state_d = REL;
                    if (act_valid_q) begin
                        for (int i = 0; i < NSRC; i++) begin
                            if (act_idx_q == 3'(i)) ackclr[i] = 1'b1;
                        end
                    end
                end
            end
            REL: begin
                act_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                act_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // Register writes; a fresh edge beats any clear landing on the same bit.
    always_comb begin
        pend_d = (pend_q & ~wclr & ~ackclr) | edge_set;
        mask_d = (wr_en && A == IRQ_MASK) ? DIn[NSRC-1:0] : mask_q;
        fsel_d = (wr_en && A == IRQ_FSEL) ? DIn[NSRC-1:0] : fsel_q;
    end

    // Read mux; idle bus reads as zero.
    always_comb begin
        DOut = 8'h00;
        if (CS && RnW) begin
            case (A)
                IRQ_PEND:   DOut = 8'(pend_q);
                IRQ_MASK:   DOut = 8'(mask_q);
                IRQ_FSEL:   DOut = 8'(fsel_q);
                IRQ_ACTIVE: DOut = {act_valid_q, 4'b0000, act_idx_q};
                default:    DOut = 8'h00;
            endcase
        end
    end

    // State registers; reset drops any in-flight acknowledge.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            req_q       <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            fsel_q      <= '0;
            nirq_q      <= 1'b1;
            nfirq_q     <= 1'b1;
            vec_q       <= DEFAULT_VEC;
            state_q     <= IDLE;
            act_idx_q   <= 3'd0;
            act_valid_q <= 1'b0;
        end else begin
            req_q       <= REQ;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            fsel_q      <= fsel_d;
            nirq_q      <= ~|irq_act;
            nfirq_q     <= ~|firq_act;
            vec_q       <= vec_d;
            state_q     <= state_d;
            act_idx_q   <= act_idx_d;
            act_valid_q <= act_valid_d;
        end
    end

    assign nIRQ      = nirq_q;
    assign nFIRQ     = nfirq_q;
    assign Intvector = vec_q;

endmodule
